// File: rtl/seq_nadder.sv
// seq_nadder: multi-cycle ripple adder/subtractor.
//
// A WIDTH-bit operand pair is added CHUNK bits per clock. The carry is held
// in a register between chunks, so the combinational carry chain is only
// CHUNK bits long. The latency from the acceptance edge to out_valid is
// N = WIDTH/CHUNK cycles.
//
// Optional feature (compile-time macro SEQ_NADDER_SAT_EN):
//   When defined, a signed overflow on the final chunk clamps out to the
//   signed max (A non-negative) or signed min (A negative). ovf still reads
//   1 and cout is unchanged. When not defined, the result wraps modulo
//   2^WIDTH and ovf is a flag only.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds in_valid (and its operands) until in_ready.
// out_valid stays high, with out/cout/ovf stable, until out_ready is seen.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair and mode valid
//   in_ready   block is IDLE and can accept an operation
//   a, b       WIDTH-bit operands
//   sub        0: A+B, 1: A-B
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts the result
//   out        sum or difference
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed overflow flag
//   busy       high in RUN or DONE
module seq_nadder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef SEQ_NADDER_SAT_EN
    localparam logic [WIDTH-1:0] MIN_S = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_S = ~MIN_S;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // holds B' (already inverted for subtract)
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic             last;
    logic             msb_cin;

    // Current chunk slice and its sum; only consumed in RUN.
    assign base    = 32'(cnt_q) * CHUNK;
    assign a_chunk = a_q[base +: CHUNK];
    assign b_chunk = b_q[base +: CHUNK];
    assign sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    assign last    = (cnt_q == CW'(N - 1));
    // Carry into the top bit of the chunk, recovered from its sum bit.
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;       // the +1 of two's complement negation
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                out_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d              = sum[CHUNK];
                cnt_d                = cnt_q + CW'(1);
                if (last) begin
                    cout_d  = sum[CHUNK];
                    ovf_d   = msb_cin ^ sum[CHUNK];
`ifdef SEQ_NADDER_SAT_EN
                    // Overflow direction follows the sign of A for both add
                    // and subtract.
                    if (msb_cin ^ sum[CHUNK]) begin
                        out_d = a_q[WIDTH-1] ? MIN_S : MAX_S;
                    end
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_nadder.sv
// Testbench for seq_nadder. Four instances share the input side:
//   d0: WIDTH=8  CHUNK=4 (N=2)   directed scenarios + random
//   d1: WIDTH=8  CHUNK=1 (N=8)
//   d2: WIDTH=8  CHUNK=8 (N=1)
//   d3: WIDTH=16 CHUNK=4 (N=4)
// Results are compared with an arithmetic reference model.
module tb_seq_nadder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        sub_i;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    int W_OF[4] = '{8, 8, 8, 16};
    int N_OF[4] = '{2, 8, 1, 4};

    logic [7:0]  out0, out1, out2;
    logic [15:0] out3;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic        v0, v1, v2, v3;
    logic        c0, c1, c2, c3;
    logic        f0, f1, f2, f3;
    logic        bz0, bz1, bz2, bz3;

    logic [15:0] o_out[4];
    logic        o_rdy[4];
    logic        o_valid[4];
    logic        o_cout[4];
    logic        o_ovf[4];
    logic        o_busy[4];

    logic [15:0] last_out;
    logic        last_cout;
    logic        last_ovf;

`ifdef SEQ_NADDER_SAT_EN
    localparam logic [7:0] T2B_EXP = 8'h7F;
    localparam logic [7:0] T3B_EXP = 8'h80;
`else
    localparam logic [7:0] T2B_EXP = 8'h80;
    localparam logic [7:0] T3B_EXP = 8'h7F;
`endif

    always #5 clk = ~clk;

    seq_nadder #(.WIDTH(8), .CHUNK(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .a(a_i[7:0]), .b(b_i[7:0]), .sub(sub_i), .out_valid(v0),
        .out_ready(out_ready), .out(out0), .cout(c0), .ovf(f0), .busy(bz0)
    );
    seq_nadder #(.WIDTH(8), .CHUNK(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a_i[7:0]), .b(b_i[7:0]), .sub(sub_i), .out_valid(v1),
        .out_ready(out_ready), .out(out1), .cout(c1), .ovf(f1), .busy(bz1)
    );
    seq_nadder #(.WIDTH(8), .CHUNK(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .a(a_i[7:0]), .b(b_i[7:0]), .sub(sub_i), .out_valid(v2),
        .out_ready(out_ready), .out(out2), .cout(c2), .ovf(f2), .busy(bz2)
    );
    seq_nadder #(.WIDTH(16), .CHUNK(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .a(a_i), .b(b_i), .sub(sub_i), .out_valid(v3),
        .out_ready(out_ready), .out(out3), .cout(c3), .ovf(f3), .busy(bz3)
    );

    assign o_out[0] = {8'h00, out0};
    assign o_out[1] = {8'h00, out1};
    assign o_out[2] = {8'h00, out2};
    assign o_out[3] = out3;
    assign o_rdy[0] = rdy0;  assign o_rdy[1] = rdy1;  assign o_rdy[2] = rdy2;  assign o_rdy[3] = rdy3;
    assign o_valid[0] = v0;  assign o_valid[1] = v1;  assign o_valid[2] = v2;  assign o_valid[3] = v3;
    assign o_cout[0] = c0;   assign o_cout[1] = c1;   assign o_cout[2] = c2;   assign o_cout[3] = c3;
    assign o_ovf[0] = f0;    assign o_ovf[1] = f1;    assign o_ovf[2] = f2;    assign o_ovf[3] = f3;
    assign o_busy[0] = bz0;  assign o_busy[1] = bz1;  assign o_busy[2] = bz2;  assign o_busy[3] = bz3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the low w bits.
    function automatic void ref_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic sv, output logic [15:0] r, output logic c,
                                   output logic v);
        int lim, ua, ub, sa, sb, t, u;
        lim = 1 << w;
        ua  = int'(av) & (lim - 1);
        ub  = int'(bv) & (lim - 1);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        if (sv) begin
            t = sa - sb;
            u = ua - ub;
            c = (ua >= ub);
        end else begin
            t = sa + sb;
            u = ua + ub;
            c = (u >= lim);
        end
        v = (t > lim / 2 - 1) || (t < -(lim / 2));
        u = ((u % lim) + lim) % lim;
`ifdef SEQ_NADDER_SAT_EN
        if (v) u = (t > 0) ? (lim / 2 - 1) : (lim / 2);
`endif
        r = 16'(u);
    endfunction

    // Launch one operation on all instances with out_ready held high and
    // check result, flags and latency of each one.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        logic [15:0] e_out[4];
        logic        e_c[4];
        logic        e_v[4];
        bit          seen[4];
        for (int d = 0; d < 4; d++) begin
            ref_op(W_OF[d], av, bv, sv, e_out[d], e_c[d], e_v[d]);
            seen[d] = 1'b0;
        end
        a_i = av; b_i = bv; sub_i = sv; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a_i = 16'($urandom); b_i = 16'($urandom); sub_i = 1'($urandom);
        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                if (!seen[d]) begin
                    if (o_valid[d]) begin
                        seen[d] = 1'b1;
                        check($sformatf("d%0d_latency", d), 32'(c), 32'(N_OF[d]));
                        check($sformatf("d%0d_out", d), 32'(o_out[d]), 32'(e_out[d]));
                        check($sformatf("d%0d_cout", d), 32'(o_cout[d]), 32'(e_c[d]));
                        check($sformatf("d%0d_ovf", d), 32'(o_ovf[d]), 32'(e_v[d]));
                        if (d == 0) begin
                            last_out = o_out[0]; last_cout = o_cout[0]; last_ovf = o_ovf[0];
                        end
                    end else begin
                        check($sformatf("d%0d_in_ready_busy", d), 32'(o_rdy[d]), 32'd0);
                    end
                end
            end
        end
        for (int d = 0; d < 4; d++) check($sformatf("d%0d_valid_seen", d), 32'(seen[d]), 32'd1);
    endtask

    task automatic drain();
        bit all_idle;
        all_idle = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !all_idle; i++) begin
            tick();
            all_idle = o_rdy[0] & o_rdy[1] & o_rdy[2] & o_rdy[3];
        end
        check("drain_idle", 32'(all_idle), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] h_out;
        logic        h_cout, h_ovf;

        // Reset
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; sub_i = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 32'(v0), 32'd0);
        check("rst_in_ready", 32'(rdy0), 32'd1);
        check("rst_busy", 32'(bz0), 32'd0);
        check("rst_out", 32'(out0), 32'd0);
        check("rst_cout", 32'(c0), 32'd0);
        check("rst_ovf", 32'(f0), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: 0x0F + 0x01
        do_op(16'h000F, 16'h0001, 1'b0);
        check("t1_out", 32'(last_out), 32'h10);
        check("t1_cout", 32'(last_cout), 32'd0);
        check("t1_ovf", 32'(last_ovf), 32'd0);

        // 2: unsigned wrap, then signed overflow
        do_op(16'h00FF, 16'h0001, 1'b0);
        check("t2a_out", 32'(last_out), 32'h00);
        check("t2a_cout", 32'(last_cout), 32'd1);
        check("t2a_ovf", 32'(last_ovf), 32'd0);
        do_op(16'h007F, 16'h0001, 1'b0);
        check("t2b_out", 32'(last_out), 32'(T2B_EXP));
        check("t2b_ovf", 32'(last_ovf), 32'd1);

        // 3: subtract with borrow, then signed overflow
        do_op(16'h0005, 16'h0007, 1'b1);
        check("t3a_out", 32'(last_out), 32'hFE);
        check("t3a_cout", 32'(last_cout), 32'd0);
        check("t3a_ovf", 32'(last_ovf), 32'd0);
        do_op(16'h0080, 16'h0001, 1'b1);
        check("t3b_out", 32'(last_out), 32'(T3B_EXP));
        check("t3b_ovf", 32'(last_ovf), 32'd1);

        // 4: backpressure on the result
        out_ready = 1'b0;
        a_i = 16'h0012; b_i = 16'h0034; sub_i = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t4_not_valid_yet", 32'(v0), 32'd0);
        tick();
        check("t4_valid", 32'(v0), 32'd1);
        check("t4_out", 32'(out0), 32'h46);
        h_out = o_out[0]; h_cout = c0; h_ovf = f0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a_i = 16'h0055; b_i = 16'h0022; sub_i = 1'b1; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check("t4_hold_valid", 32'(v0), 32'd1);
            check("t4_hold_out", 32'(o_out[0]), 32'(h_out));
            check("t4_hold_cout", 32'(c0), 32'(h_cout));
            check("t4_hold_ovf", 32'(f0), 32'(h_ovf));
            check("t4_hold_in_ready", 32'(rdy0), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("t4_release_valid", 32'(v0), 32'd0);
        check("t4_release_in_ready", 32'(rdy0), 32'd1);
        tick();
        check("t4_pulse_ignored", 32'(bz0), 32'd0);
        drain();

        // 5: reset one cycle after acceptance
        out_ready = 1'b1;
        a_i = 16'h00AA; b_i = 16'h0011; sub_i = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("t5_out_valid", 32'(v0), 32'd0);
        check("t5_out", 32'(out0), 32'd0);
        check("t5_in_ready", 32'(rdy0), 32'd1);
        check("t5_busy", 32'(bz0), 32'd0);
        rst_n = 1'b1;
        tick();
        do_op(16'h0003, 16'h0004, 1'b0);
        check("t5_after_out", 32'(last_out), 32'h07);

        // 6: random sweep across all parameter sets
        for (int i = 0; i < 1000; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
